// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared types and defaults for the tick edge sequencer
package tick_pkg;

    // Default width of the cycle counter and of the event cycle field.
    localparam int TICK_CNT_W = 16;

    // Default cycle number above which an event is flagged as the last one.
    localparam int TICK_LIMIT = 20;

    // Default event FIFO depth in entries (power of 2, at least 2).
    localparam int TICK_DEPTH = 2;

    // One queued event: cycle number, its parity and the final-event flag.
    typedef struct packed {
        logic [TICK_CNT_W-1:0] cyc;
        logic                  odd;
        logic                  last;
    } evt_t;

    // Build an event from a cycle number; last when the number exceeds limit.
    function automatic evt_t make_evt(input logic [TICK_CNT_W-1:0] n,
                                      input logic [TICK_CNT_W-1:0] limit);
        evt_t e;
        e.cyc  = n;
        e.odd  = n[0];
        e.last = (n > limit);
        return e;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - small valid/ready event FIFO with full-with-pop push
module evt_fifo
    import tick_pkg::*;
#(
    parameter int  DEPTH = TICK_DEPTH,
    parameter type T     = evt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    output logic full,
    input  logic pop,
    output T     head,
    output logic valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == OCC_W'(DEPTH));
    assign do_pop  = pop & valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Head reads zero when empty so stale storage never shows on the outputs.
    always_comb begin
        head = '0;
        if (valid) begin
            head = mem[rd_ptr];
        end
    end

    // Storage write; payload needs no reset because valid masks it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of 2; occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tick_edge_sequencer.sv
// rtl/tick_edge_sequencer.sv - counts tick rising edges and queues cycle events
module tick_edge_sequencer
    import tick_pkg::*;
#(
    parameter int CNT_W = TICK_CNT_W,
    parameter int LIMIT = TICK_LIMIT,
    parameter int DEPTH = TICK_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_cyc,
    output logic             evt_odd,
    output logic             evt_last,
    output logic [CNT_W-1:0] cyc_count,
    output logic             finished,
    output logic             overflow
);

    // Event layout sized by this instance's counter width.
    typedef struct packed {
        logic [CNT_W-1:0] cyc;
        logic             odd;
        logic             last;
    } seq_evt_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic             tick_prev;
    logic             rise;
    logic             count_evt;
    logic [CNT_W-1:0] next_cyc;
    logic             pop;
    logic             fifo_full;
    logic             drop;
    seq_evt_t         new_evt;
    seq_evt_t         head_evt;

    // A counted edge is a rising tick while enabled and not yet finished.
    assign rise      = tick_in & ~tick_prev;
    assign count_evt = rise & enable & ~finished;
    assign next_cyc  = cyc_count + 1'b1;
    assign pop       = evt_valid & evt_ready;
    // Dropped when the FIFO is full and nothing leaves this cycle.
    assign drop      = count_evt & fifo_full & ~pop;

    // Payload of the event that the current edge would generate.
    always_comb begin
        new_evt      = '0;
        new_evt.cyc  = next_cyc;
        new_evt.odd  = next_cyc[0];
        new_evt.last = (next_cyc > LIMIT_C);
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .T     (seq_evt_t)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (count_evt),
        .push_data (new_evt),
        .full      (fifo_full),
        .pop       (pop),
        .head      (head_evt),
        .valid     (evt_valid)
    );

    assign evt_cyc  = head_evt.cyc;
    assign evt_odd  = head_evt.odd;
    assign evt_last = head_evt.last;

    // Edge history always follows tick_in so held levels never count later.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_in;
        end
    end

    // Cycle counter advances on every counted edge, even when the event drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_count <= '0;
        end else if (count_evt) begin
            cyc_count <= next_cyc;
        end
    end

    // Sticky status: finished on generating the last event, overflow on a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            finished <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (count_evt && new_evt.last) begin
                finished <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_edge_sequencer.sv
// tb/tb_tick_edge_sequencer.sv - randomized self-checking bench for tick_edge_sequencer
module tb_tick_edge_sequencer;

    localparam int CNT_W = 16;
    localparam int LIMIT = 20;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             tick_in;
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_cyc;
    logic             evt_odd;
    logic             evt_last;
    logic [CNT_W-1:0] cyc_count;
    logic             finished;
    logic             overflow;

    tick_edge_sequencer #(
        .CNT_W (CNT_W),
        .LIMIT (LIMIT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .tick_in   (tick_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_cyc   (evt_cyc),
        .evt_odd   (evt_odd),
        .evt_last  (evt_last),
        .cyc_count (cyc_count),
        .finished  (finished),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a queue of pending events plus the scalar status.
    typedef struct {
        int cyc;
        bit last;
    } mevt_t;

    mevt_t mq[$];
    int    m_cnt  = 0;
    bit    m_prev = 0;
    bit    m_fin  = 0;
    bit    m_ovf  = 0;

    int dut_pops     = 0;
    int dut_last_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int  ecyc;
        bit  elast;
        bit  evalid;
        evalid = (mq.size() > 0);
        ecyc   = evalid ? mq[0].cyc : 0;
        elast  = evalid ? mq[0].last : 1'b0;
        check("evt_valid", 32'(evt_valid), 32'(evalid));
        check("evt_cyc",   32'(evt_cyc),   32'(ecyc));
        check("evt_odd",   32'(evt_odd),   32'(ecyc & 1));
        check("evt_last",  32'(evt_last),  32'(elast));
        check("cyc_count", 32'(cyc_count), 32'(m_cnt));
        check("finished",  32'(finished),  32'(m_fin));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit r, input bit e, input bit t, input bit rd);
        bit    pop;
        bit    acc;
        int    n;
        mevt_t ev;
        rst       = r;
        enable    = e;
        tick_in   = t;
        evt_ready = rd;
        if (!r && evt_valid && rd) begin
            dut_pops++;
            if (evt_last) dut_last_cyc = int'(evt_cyc);
        end
        pop = (mq.size() > 0) && rd;
        if (r) begin
            mq.delete();
            m_cnt  = 0;
            m_prev = 0;
            m_fin  = 0;
            m_ovf  = 0;
        end else begin
            if (t && !m_prev && e && !m_fin) begin
                n   = (m_cnt + 1) % (1 << CNT_W);
                acc = (mq.size() < DEPTH) || pop;
                m_cnt = n;
                if (n > LIMIT) m_fin = 1;
                if (pop) void'(mq.pop_front());
                ev.cyc  = n;
                ev.last = (n > LIMIT);
                if (acc) mq.push_back(ev);
                else     m_ovf = 1;
            end else if (pop) begin
                void'(mq.pop_front());
            end
            m_prev = t;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        tick_in   = 1'b0;
        evt_ready = 1'b1;
        @(negedge clk);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);

        // Regular run: tick toggles every 10 clocks, consumer always ready.
        dut_pops     = 0;
        dut_last_cyc = -1;
        for (int i = 0; i < 500; i++) begin
            step(0, 1, bit'((i / 10) & 1), 1);
        end
        check("plan_pops", 32'(dut_pops), 32'd21);
        check("plan_last_cyc", 32'(dut_last_cyc), 32'd21);

        // Stalled consumer with three edges into a two-deep FIFO.
        step(1, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, bit'(i & 1), 0);
        end
        check("stall_count", 32'(cyc_count), 32'd3);
        check("stall_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
        end

        // Full FIFO with an edge coinciding with a pop.
        step(1, 1, 0, 1);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        check("full_pop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
        end

        // Edges while disabled, then enable with tick held high.
        step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        check("dis_count", 32'(cyc_count), 32'd0);
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        check("dis_first", 32'(evt_cyc), 32'd1);

        // Randomized traffic with occasional mid-run reset.
        begin
            bit t;
            t = 0;
            for (int i = 0; i < 20000; i++) begin
                if ($urandom_range(2) == 0) t = ~t;
                step(($urandom_range(399) == 0),
                     ($urandom_range(9) != 0),
                     t,
                     ($urandom_range(9) < 7));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_edge_sequencer.md
Name: tick_edge_sequencer

Overview:
- Downstream consumer of a generated toggle clock. Samples tick_in in the clk domain and detects its rising edges.
- Counts those edges as "cycles" and emits one event per edge into a small valid/ready FIFO. Each event carries the cycle number, its parity and a last flag.
- Raises a sticky finished flag once the count exceeds LIMIT.
- Produces the +/-/finish event stream that scheduler test benches drain and print.

Parameters:
- CNT_W, 16, width of the cycle counter and of evt_cyc.
- LIMIT, 20, the event whose cycle number is greater than LIMIT is flagged last.
- DEPTH, 2, event FIFO depth in entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all logic is on posedge clk.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, edges are not counted.
- tick_in  in  1  generated toggle signal, synchronous to clk.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_cyc  out  CNT_W  cycle number of the head event.
- evt_odd  out  1  evt_cyc[0].
- evt_last  out  1  the head event is the final event.
- cyc_count  out  CNT_W  current edge count.
- finished  out  1  sticky; the last event has been generated.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at posedge):
  - tick_prev, cyc_count, finished, overflow, FIFO pointers and count all go to 0.
  - evt_valid=0; evt_cyc, evt_odd and evt_last read 0.
  - Reset mid-operation discards all queued events. No partial output is produced.
- Edge detect:
  - edge = tick_in & ~tick_prev.
  - tick_prev <= tick_in every cycle, regardless of enable or finished. A falling edge, or a level held across enable toggling, never yields an event.
- Count:
  - On edge & enable & ~finished: cyc_count <= cyc_count+1, wrapping modulo 2^CNT_W.
  - The new value n is the event payload: evt_cyc=n, evt_odd=n[0], evt_last=(n > LIMIT), compared unsigned.
- Finish:
  - When an event with last=1 is generated, finished <= 1 in the same cycle.
  - Later edges are ignored: no count, no event, no overflow.
  - finished rises even if that last event is dropped.
- FIFO push:
  - Push is attempted on an edge that is counted.
  - The push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (full-with-pop is allowed).
  - Otherwise the event is dropped, overflow <= 1 (sticky), and cyc_count still increments.
- FIFO pop:
  - Pop occurs when evt_valid & evt_ready.
  - The head is registered; the next entry appears on the following cycle.
  - Simultaneous push and pop leave the count unchanged.
  - Pop on empty is a no-op.
- Latency: tick_in rising seen at cycle N (tick_in=1, tick_prev=0) gives the counted event with evt_valid=1 at cycle N+1, if the FIFO was empty.
- Ordering: events leave strictly in cycle order. evt_* outputs are stable while evt_valid & ~evt_ready.
- Wrap: if cyc_count wraps, n restarts at 0 and is emitted normally. LIMIT must be below 2^CNT_W-1, otherwise last never fires.

Decomposition:
- Shared package tick_pkg:
  - typedef evt_t as a packed struct {cyc[CNT_W], odd, last}.
  - Default CNT_W and LIMIT constants.
- One sub-module: evt_fifo.
  - Parameterised on DEPTH; element type evt_t.
  - Ports push, push_data, full, pop, head, valid.
- Edge detect, counter and finish logic stay in the top module.

Test Plan:
- tick_in toggles every 10 clk, evt_ready=1, LIMIT=20 -> 21 events with evt_cyc 1..21 and evt_odd alternating 1,0,1,… ; evt_last=1 only on cyc 21; finished=1 one cycle after the 21st edge; no further events; overflow=0.
- Single rising edge at cycle 5 with FIFO empty -> evt_valid=1 at cycle 6 with evt_cyc=1; cyc_count=1.
- evt_ready=0, 3 edges, DEPTH=2 -> FIFO holds cyc 1,2; overflow=1; cyc_count=3; then evt_ready=1 -> events 1 and 2 drain in order, then evt_valid=0.
- FIFO full, and an edge coincides with a pop -> the push is accepted, count stays at 2, overflow stays 0.
- enable=0 across 2 rising edges, then enable=1 while tick_in is high -> no events, cyc_count=0; the next true rising edge gives evt_cyc=1.
- rst asserted after event 7 with 2 events queued -> next cycle evt_valid=0, cyc_count=0, finished=0, overflow=0; the next edge gives evt_cyc=1.
